// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial WIDTH-bit adder/subtractor built around a single full-add slice.
//   One bit is processed per clock, LSB first. The block owns the operand
//   shift registers, the carry flop, the bit counter and the Start/Busy/Done
//   handshake. Result, CarryOut and Overflow are registered and only change
//   when an operation completes.
//
// Ports
//   Clk       in   system clock, rising edge
//   Rst_n     in   asynchronous active-low reset
//   Start     in   request an operation (sampled only while idle)
//   Sub       in   0: A+B, 1: A-B (sampled with Start)
//   A, B      in   operands (sampled with Start)
//   Busy      out  high while bits are being processed
//   Done      out  one-cycle pulse when Result is valid
//   Result    out  sum/difference, held until the next completion
//   CarryOut  out  carry out of the MSB (for subtract, 1 = no borrow)
//   Overflow  out  two's-complement overflow
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_partial;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;

  logic             w_sum;
  logic             w_cout;
  logic             w_last;

  // The single full-add slice.
  assign w_sum  = r_op_a[0] ^ r_op_b[0] ^ r_carry;
  assign w_cout = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
  assign w_last = (r_cnt == LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred for w_next.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (Start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;   // Start is ignored here, no queuing
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    unique case (r_state)
      S_RUN:   Busy = 1'b1;
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  assign Result   = r_result;
  assign CarryOut = r_carry_out;
  assign Overflow = r_overflow;

  // ---------------------------------------------------------------------------
  // Datapath: operand shift registers, carry, counter, partial and results
  // ---------------------------------------------------------------------------
  // NOTE: every datapath register is reset so an aborted operation leaves no
  // stale operand, carry or partial sum behind.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_partial   <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_op_a    <= A;
            // Subtract is A + ~B + 1: invert B and preload the carry with 1.
            r_op_b    <= Sub ? ~B : B;
            r_carry   <= Sub;
            r_cnt     <= '0;
            r_partial <= '0;
          end
        end
        S_RUN: begin
          r_op_a    <= r_op_a >> 1;
          r_op_b    <= r_op_b >> 1;
          r_carry   <= w_cout;
          r_cnt     <= r_cnt + 1'b1;
          r_partial <= {w_sum, r_partial[WIDTH-1:1]};
          if (w_last) begin
            // Capture including the bit being added on this edge; r_carry
            // here is the carry into the MSB.
            r_result    <= {w_sum, r_partial[WIDTH-1:1]};
            r_carry_out <= w_cout;
            r_overflow  <= r_carry ^ w_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
